// File: rtl/interval_meter.sv
// interval_meter: measures the high time of sig in units of PERIOD = FCLK/SCALE clocks.
// The measurement saturates at MAX_UNITS, which sets ovf.
// Optional feature: define INTERVAL_METER_SYNC_EN to pass sig through a two-flop synchronizer
// before edge detection. This adds 2 cycles of latency and leaves width unchanged.
module interval_meter #(
    parameter int unsigned FCLK      = 100000000,
    parameter int unsigned SCALE     = 1000,
    parameter logic [31:0] MAX_UNITS = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enbl,
    input  logic        sig,
    output logic [31:0] width,
    output logic        valid,
    output logic        busy,
    output logic        ovf
);

    localparam int unsigned PERIOD = FCLK / SCALE;
    localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_t;

    logic          sig_s;
    logic          sig_d;
    logic          rise;
    logic          fall;
    logic          tick;
    logic [32:0]   sum;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_clk_q, cnt_clk_d;
    logic [31:0]   cnt_time_q, cnt_time_d;
    logic [31:0]   width_q, width_d;
    logic          ovf_q, ovf_d;
    logic          valid_q, valid_d;

`ifdef INTERVAL_METER_SYNC_EN
    logic sync1, sync2;

    // Two-flop synchronizer; reset high so a line held high at reset release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= sig;
            sync2 <= sync1;
        end
    end

    assign sig_s = sync2;
`else
    assign sig_s = sig;
`endif

    // Edge history, updated every cycle regardless of enbl.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_d <= 1'b1;
        end else begin
            sig_d <= sig_s;
        end
    end

    assign rise = sig_s & ~sig_d;
    assign fall = ~sig_s & sig_d;
    assign tick = (cnt_clk_q == LAST);
    // Widened sum so the compare against MAX_UNITS can never wrap.
    assign sum  = {1'b0, cnt_time_q} + {32'b0, tick};

    // State, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_clk_q  <= '0;
            cnt_time_q <= '0;
            width_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_clk_q  <= cnt_clk_d;
            cnt_time_q <= cnt_time_d;
            width_q    <= width_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    // Next-state logic: enbl low overrides everything; a fall ending the pulse wins over
    // saturation when both happen in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_clk_d  = cnt_clk_q;
        cnt_time_d = cnt_time_q;
        width_d    = width_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        if (!enbl) begin
            state_d    = StIdle;
            cnt_clk_d  = '0;
            cnt_time_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d    = StRun;
                        cnt_clk_d  = '0;
                        cnt_time_d = '0;
                    end
                end
                StRun: begin
                    if (fall) begin
                        width_d    = sum[31:0];
                        ovf_d      = 1'b0;
                        valid_d    = 1'b1;
                        state_d    = StIdle;
                        cnt_clk_d  = '0;
                        cnt_time_d = '0;
                    end else if (sum >= {1'b0, MAX_UNITS}) begin
                        width_d    = MAX_UNITS;
                        ovf_d      = 1'b1;
                        valid_d    = 1'b1;
                        state_d    = StHold;
                        cnt_clk_d  = '0;
                        cnt_time_d = '0;
                    end else begin
                        cnt_clk_d  = tick ? '0 : cnt_clk_q + CW'(1);
                        cnt_time_d = sum[31:0];
                    end
                end
                StHold: begin
                    // Wait out the saturated pulse; a fresh rise is needed afterwards.
                    if (!sig_s) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign width = width_q;
    assign ovf   = ovf_q;
    assign valid = valid_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_interval_meter.sv
// Scoreboard bench for interval_meter (FCLK=1000, SCALE=100 -> PERIOD=10, MAX_UNITS=4).
// Expected results come from the pulse length: width = floor(N/PERIOD), or MAX_UNITS with ovf
// when N > MAX_UNITS*PERIOD.
module tb_interval_meter;

    localparam int unsigned FCLK  = 1000;
    localparam int unsigned SCALE = 100;
    localparam int unsigned P     = FCLK / SCALE;
    localparam int unsigned MAXU  = 4;
`ifdef INTERVAL_METER_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enbl;
    logic        sig;
    logic [31:0] width;
    logic        valid;
    logic        busy;
    logic        ovf;

    typedef struct {
        logic [31:0] w;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [31:0] mon_w       = '0;
    logic        mon_o       = 1'b0;
    logic [31:0] last_w      = '0;
    logic        last_o      = 1'b0;

    interval_meter #(
        .FCLK      (FCLK),
        .SCALE     (SCALE),
        .MAX_UNITS (32'(MAXU))
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .enbl  (enbl),
        .sig   (sig),
        .width (width),
        .valid (valid),
        .busy  (busy),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid pops one expectation; outside valid the outputs must hold.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("width", width, e.w);
                    chk("ovf", ovf, e.o);
                    chk("valid_cycle", cyc, e.cyc);
                    mon_w = e.w;
                    mon_o = e.o;
                end
            end else begin
                chk("width_hold", width, mon_w);
                chk("ovf_hold", ovf, mon_o);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // High pulse of n cycles; d >= 0 drops enbl for 3 cycles starting at high cycle d.
    task automatic pulse(input int n, input int d, input int gap);
        exp_t e;
        int   r;
        bit   exp_ovf;
        r       = cyc;
        exp_ovf = (n > int'(MAXU * P));
        if (d < 0) begin
            if (exp_ovf) begin
                e.w   = MAXU;
                e.o   = 1'b1;
                e.cyc = r + int'(MAXU * P) + 1 + SYNC;
            end else begin
                e.w   = 32'(n / int'(P));
                e.o   = 1'b0;
                e.cyc = r + n + 1 + SYNC;
            end
            sb.push_back(e);
            last_w = e.w;
            last_o = e.o;
        end
        sig = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (d >= 0 && i == d) enbl = 1'b0;
            if (d >= 0 && i == d + 3) enbl = 1'b1;
            if (d < 0 && exp_ovf && i == n - 1) chk("busy_while_high", busy, 1);
            step(1);
        end
        enbl = 1'b1;
        sig  = 1'b0;
        step(gap);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int n;
        int mode;
        rst  = 1'b1;
        enbl = 1'b1;
        sig  = 1'b1;
        step(3);
        chk("rst_width", width, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // sig already high at reset release must not be measured.
        step(3);
        chk("no_start_after_rst", busy, 0);
        sig = 1'b0;
        step(5);
        pulse(20, -1, 6);

        pulse(35, -1, 6);
        pulse(30, -1, 6);
        pulse(9, -1, 6);
        pulse(100, -1, 6);

        // Aborted pulse: no valid, previous result held.
        pulse(35, 15, 6);
        chk("abort_width", width, last_w);
        chk("abort_ovf", ovf, last_o);

        // enbl raised while sig high must wait for the next rise.
        enbl = 1'b0;
        sig  = 1'b1;
        step(4);
        enbl = 1'b1;
        step(20);
        chk("no_start_mid_pulse", busy, 0);
        sig = 1'b0;
        step(5);

        for (int k = 0; k < 40; k++) begin
            mode = $urandom_range(0, 4);
            if (mode == 0) begin
                n = $urandom_range(6, 39);
                pulse(n, $urandom_range(2, n - 1), $urandom_range(4, 8));
            end else begin
                n = $urandom_range(1, 60);
                if (n == int'(MAXU * P)) n = n - 1;
                pulse(n, -1, $urandom_range(4, 8));
            end
        end

        for (int t = 0; t < 200 && sb.size() != 0; t++) step(1);
        while (sb.size() != 0) begin
            void'(sb.pop_front());
            chk("missing_valid", 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
